mux_scan_ctrl: RTL and testbench

- Sequencer that sits directly upstream and downstream of the 8:1 mux (`mux_dig`).
- Drives the mux select lines s2/s1/s0 through channels 0..7 and waits a programmable settle time on each channel.
- Samples the mux output y once per channel and assembles the eight bits into a parallel word.
- Gives the rest of the design a start/done handshake in place of hand-driven selects.

---
 rtl/mux_scan_pkg.sv | 15 +
 rtl/mux_scan_ctrl_if.sv | 36 +++
 rtl/mux_scan_ctrl_settle_timer.sv | 36 +++
 rtl/mux_scan_ctrl.sv | 112 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux scan sequencer
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam logic [SEL_W-1:0] LAST_CH = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - start/done handshake plus mux select/sample lines
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              start;
    logic              y;
    logic              s2;
    logic              s1;
    logic              s0;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] word;

    modport master (
        output start,
        output y,
        input  s2,
        input  s1,
        input  s0,
        input  busy,
        input  done,
        input  word
    );

    modport slave (
        input  start,
        input  y,
        output s2,
        output s1,
        output s0,
        output busy,
        output done,
        output word
    );

endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// rtl/mux_scan_ctrl_settle_timer.sv - loadable down-counter with zero flag
module settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over decrement; the counter saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - steps an 8:1 mux through all channels and assembles the sampled word
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] word_q, word_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    assign timer_load = ((state_q == IDLE) && bus.start) ||
                        ((state_q == SAMPLE) && (sel_q != LAST_CH));
    assign timer_dec  = (state_q == SETTLE);

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        word_d   = word_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                sel_d  = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = SETTLE;
                    busy_d  = 1'b1;
                end
            end
            SETTLE: begin
                if (timer_zero) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                shadow_d[sel_q] = bus.y;
                if (sel_q == LAST_CH) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end else begin
                    sel_d   = sel_q + 1'b1;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                // Publish the full word in a single edge so consumers never see a partial scan.
                word_d  = shadow_q;
                done_d  = 1'b1;
                sel_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            word_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            word_q   <= word_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.s2   = sel_q[2];
    assign bus.s1   = sel_q[1];
    assign bus.s0   = sel_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.word = word_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - checks mux_scan_ctrl against a cycle-count reference of the scan timing
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_r [3];
    logic [7:0] d_r [3];
    logic [7:0] exp_word [3];
    logic       y1_q = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl_if b0 ();
    mux_scan_ctrl_if b1 ();
    mux_scan_ctrl_if b2 ();

    mux_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    mux_scan_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mux_scan_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    assign b0.start = start_r[0];
    assign b1.start = start_r[1];
    assign b2.start = start_r[2];

    // Ideal mux on dut0/dut2; mux with one cycle of output lag on dut1.
    assign b0.y = d_r[0][{b0.s2, b0.s1, b0.s0}];
    assign b2.y = d_r[2][{b2.s2, b2.s1, b2.s0}];
    always @(posedge clk) y1_q <= d_r[1][{b1.s2, b1.s1, b1.s0}];
    assign b1.y = y1_q;

    function automatic int settle_of(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 0;
        endcase
    endfunction

    // {sel[2:0], busy, done, word[7:0]}
    function automatic logic [12:0] obs_of(int i);
        case (i)
            0:       return {b0.s2, b0.s1, b0.s0, b0.busy, b0.done, b0.word};
            1:       return {b1.s2, b1.s1, b1.s0, b1.busy, b1.done, b1.word};
            default: return {b2.s2, b2.s1, b2.s0, b2.busy, b2.done, b2.word};
        endcase
    endfunction

    task automatic chk(string tag, int c, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic chk_all(int i, int c, logic [2:0] esel, logic ebusy, logic edone, logic [7:0] eword);
        logic [12:0] o;
        o = obs_of(i);
        chk($sformatf("dut%0d sel", i), c, {5'd0, o[12:10]}, {5'd0, esel});
        chk($sformatf("dut%0d busy", i), c, {7'd0, o[9]}, {7'd0, ebusy});
        chk($sformatf("dut%0d done", i), c, {7'd0, o[8]}, {7'd0, edone});
        chk($sformatf("dut%0d word", i), c, o[7:0], eword);
    endtask

    // One scan: a channel lasts s+2 cycles, DONE follows channel 7, done shows one cycle later.
    task automatic scan(int i, logic [7:0] data, int restart_cyc, int rst_cyc);
        int s;
        int per;
        int lat;
        int ch;
        s   = settle_of(i);
        per = s + 2;
        lat = 8 * per + 1;
        d_r[i] = data;
        @(negedge clk);
        start_r[i] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            start_r[i] = (c == restart_cyc);
            ch = c / per;
            if (ch > 7) ch = 7;
            if (c < lat) begin
                chk_all(i, c, 3'(ch), (c < 8 * per), 1'b0, exp_word[i]);
            end else if (c == lat) begin
                exp_word[i] = data;
                chk_all(i, c, 3'd0, 1'b0, 1'b1, exp_word[i]);
            end else begin
                chk_all(i, c, 3'd0, 1'b0, 1'b0, exp_word[i]);
            end
            if (c == rst_cyc) begin
                start_r[i] = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 3; k++) exp_word[k] = 8'h00;
                chk_all(i, c + 1, 3'd0, 1'b0, 1'b0, 8'h00);
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    chk_all(i, c + 2 + k, 3'd0, 1'b0, 1'b0, 8'h00);
                end
                return;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_r[k]  = 1'b0;
            d_r[k]      = 8'h00;
            exp_word[k] = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk_all(k, -1, 3'd0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        scan(0, 8'hA5, -1, -1);
        scan(1, 8'h3C, -1, -1);
        scan(0, 8'h5A, -1, -1);
        scan(0, 8'($urandom), 10, -1);
        scan(1, 8'($urandom), -1, -1);
        scan(0, 8'($urandom), -1, 15);
        scan(0, 8'($urandom), -1, -1);
        scan(2, 8'hFF, -1, -1);
        scan(2, 8'h00, -1, -1);
        for (int n = 0; n < 6; n++) begin
            scan(int'($urandom_range(0, 2)), 8'($urandom), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
